ip_tx_arbiter: RTL
==================

# ip_tx_arbiter

Shares the single IP header-insertion datapath (`ip_send`) between several payload sources in the Ethernet transmit path, e.g. the UDP data stream, ICMP echo replies and the discovery/DHCP responder. The block selects one requester at a time and latches its header fields. It presents those fields to `ip_send` during the one inactive cycle `ip_send` needs to load its header. It then meters exactly `length` payload bytes out of the requester and holds off the next frame until `ip_send` has drained.

## Interface
Parameters:
- `NUM_REQ`, 3: number of requesters, 2..8; index 0 is highest fixed priority.
- `DRAIN_TIMEOUT`, 64: maximum cycles to wait for `ip_active` low after the payload ends.

Ports:
- `clock`  in  1  single clock domain for the whole block.
- `reset`  in  1  synchronous, active-low reset.
- `req`  in  NUM_REQ  per-requester frame request; held high until its `done` pulse.
- `req_is_icmp`  in  NUM_REQ  per-requester protocol select; must be stable while `req` is high.
- `req_length`  in  NUM_REQ*16  payload byte count, excluding the IP header; stable while `req` is high.
- `req_destination_ip`  in  NUM_REQ*32  destination address; stable while `req` is high.
- `req_data`  in  NUM_REQ*8  payload byte, valid in any cycle where that requester's `rd` is high.
- `gnt`  out  NUM_REQ  one-hot grant, held from LOAD through DRAIN.
- `rd`  out  NUM_REQ  byte-consumed strobe; the requester advances to its next byte after each high cycle.
- `done`  out  NUM_REQ  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse on a zero-length request or a drain timeout.
- `busy`  out  1  high in any state other than IDLE.
- `ip_tx_enable`, `ip_is_icmp`, `ip_length[15:0]`, `ip_destination_ip[31:0]`, `ip_data[7:0]`  out  these drive the corresponding `ip_send` inputs.
- `ip_active`  in  1  the `active` output of `ip_send`.

## Operation
- The FSM states are IDLE, LOAD, SEND, DRAIN.
- **IDLE**
  - If any `req` bit is high and `ip_active` is low, pick a winner `w`.
  - Register `gnt[w]`.
  - Latch `is_icmp`, `length` and `destination_ip` into header registers.
  - Go to LOAD.
  - If `ip_active` is high, stay in IDLE.
- **LOAD** (exactly 1 cycle)
  - `ip_tx_enable` = 0; `ip_send` loads its header from the latched fields this cycle.
  - If the latched length is 0: pulse `done[w]` and `err`, clear `gnt`, go to IDLE.
  - Otherwise load the byte counter with `length` and go to SEND.
- **SEND**
  - `ip_tx_enable` = 1 and `rd[w]` = 1.
  - `ip_data` = `req_data[w]`, combinationally muxed.
  - The 16-bit counter decrements each cycle; after the cycle in which it equals 1, go to DRAIN.
  - SEND therefore lasts exactly `length` cycles.
- **DRAIN**
  - `ip_tx_enable` = 0.
  - Wait for `ip_active` = 0, which occurs 21 cycles after `ip_tx_enable` falls.
  - Then pulse `done[w]`, clear `gnt`, go to IDLE.
  - Count the wait; if `DRAIN_TIMEOUT` cycles pass, pulse `done[w]` and `err` anyway and go to IDLE.
- `ip_is_icmp`, `ip_length` and `ip_destination_ip` hold the latched values from LOAD until the next latch.
- `ip_data` = 0 outside SEND.
- A requester dropping `req` mid-frame is ignored; the frame completes, and garbage payload is the requester's fault.
- New requests arriving during a frame are evaluated only in IDLE.

## Timing
- Reset values: FSM = IDLE; `gnt`, `rd`, `done`, `err`, `busy`, `ip_tx_enable` = 0; header registers = 0; `ip_data` = 0.
- `req` sampled high in IDLE at edge t: `gnt`/LOAD from t+1, `ip_tx_enable`/`rd` from t+2 through t+1+length.
- `done` occurs at the earliest one cycle after `ip_active` is sampled low.
- Minimum spacing between frames is one IDLE cycle plus one LOAD cycle.
- `length` = 65535 must work; the counter must not wrap.
- Reset asserted mid-frame returns to IDLE on that edge. No `done` is issued.

## Configuration
- `IP_TX_ARB_RR_EN` defined: round-robin arbitration. The search starts at the index after the last winner. After reset, the search starts at index 0.
- Not defined: fixed priority, lowest index wins. No last-winner register is synthesised.

## Structure
- Package `ip_tx_arb_pkg` holds:
  - the state enum `ip_tx_arb_state_t` (IDLE, LOAD, SEND, DRAIN);
  - the `IP_HDR_DRAIN_CYCLES = 21` constant;
  - the `MAX_NUM_REQ = 8` limit.
- Sub-module `ip_tx_arb_picker`: combinational one-hot winner from `req` and the last-winner pointer; the pointer is unused when round-robin is off.

## Test plan
- Single request: `req[0]` with length 8, ICMP=0, dest 192.168.1.10 → `gnt[0]` at t+1, exactly 8 `rd[0]`/`ip_tx_enable` cycles, `ip_*` fields stable from LOAD onward, `done[0]` once `ip_active` falls.
- Simultaneous `req[2:0]` = 3'b111:
  - fixed build → grant order 0, 0, 0 while `req[0]` stays high;
  - `IP_TX_ARB_RR_EN` build → grant order 0, 1, 2.
- Zero length on `req[1]` → LOAD only, `done[1]` and `err` pulse, `ip_tx_enable` never high.
- `ip_active` stuck high after SEND → `err` and `done` pulse exactly `DRAIN_TIMEOUT` cycles after entering DRAIN.
- `reset` low during SEND with length 1000 → next edge all outputs 0 and state IDLE; after release, a new request is granted normally.
- Length 65535 → exactly 65535 `rd` pulses, no wrap, single `done`.

Source files
------------

// File: rtl/ip_tx_arb_pkg.sv
// Shared types and constants for the ip_send transmit arbiter.
package ip_tx_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SEND,
      DRAIN
   } ip_tx_arb_state_t;

   localparam int IP_HDR_DRAIN_CYCLES = 21;
   localparam int MAX_NUM_REQ         = 8;
   localparam int IDX_W               = $clog2(MAX_NUM_REQ);

   // (base + inc) modulo n, for base < n and inc <= n
   function automatic int wrap_add(input int base, input int inc, input int n);
      return (base + inc >= n) ? base + inc - n : base + inc;
   endfunction

endpackage

// File: rtl/ip_tx_arb_picker.sv
// Combinational one-hot winner selection. IP_TX_ARB_RR_EN: round-robin from i_start;
// otherwise fixed priority with index 0 highest and i_start ignored.
module ip_tx_arb_picker
   import ip_tx_arb_pkg::*;
#(
   parameter int NUM_REQ = 3
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_start,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [IDX_W-1:0]   o_idx
);

`ifndef IP_TX_ARB_RR_EN
   logic w_unused_start;
   assign w_unused_start = ^i_start;
`endif

   always_comb begin
      // NOTE: defaults come first so every path assigns both outputs and no latch is inferred.
      o_gnt = '0;
      o_idx = '0;
`ifdef IP_TX_ARB_RR_EN
      // Walk search offsets from farthest to nearest so the nearest request is written last.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (i_req[i] && (i == wrap_add(int'(i_start), k, NUM_REQ))) begin
               o_gnt    = '0;
               o_gnt[i] = 1'b1;
               o_idx    = IDX_W'(i);
            end
         end
      end
`else
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_gnt    = '0;
            o_gnt[i] = 1'b1;
            o_idx    = IDX_W'(i);
         end
      end
`endif
   end

endmodule

// File: rtl/ip_tx_arbiter.sv
// Shares the ip_send header/payload datapath between NUM_REQ payload sources.
// Define IP_TX_ARB_RR_EN for round-robin arbitration; fixed priority otherwise.
module ip_tx_arbiter
   import ip_tx_arb_pkg::*;
#(
   parameter int NUM_REQ       = 3,
   parameter int DRAIN_TIMEOUT = 64
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [NUM_REQ-1:0]      req_is_icmp,
   input  logic [NUM_REQ*16-1:0]   req_length,
   input  logic [NUM_REQ*32-1:0]   req_destination_ip,
   input  logic [NUM_REQ*8-1:0]    req_data,
   output logic [NUM_REQ-1:0]      gnt,
   output logic [NUM_REQ-1:0]      rd,
   output logic [NUM_REQ-1:0]      done,
   output logic                    err,
   output logic                    busy,
   output logic                    ip_tx_enable,
   output logic                    ip_is_icmp,
   output logic [15:0]             ip_length,
   output logic [31:0]             ip_destination_ip,
   output logic [7:0]              ip_data,
   input  logic                    ip_active
);

   localparam int                DCNT_W     = $clog2(DRAIN_TIMEOUT + 1);
   localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_TIMEOUT - 1);

   ip_tx_arb_state_t   r_state;
   logic [NUM_REQ-1:0] r_gnt, r_rd, r_done;
   logic               r_err, r_busy, r_tx_en, r_is_icmp;
   logic [15:0]        r_length, r_cnt;
   logic [31:0]        r_dest;
   logic [DCNT_W-1:0]  r_drain_cnt;

   logic [NUM_REQ-1:0] w_pick_gnt;
   logic [IDX_W-1:0]   w_pick_idx, w_start;
   logic               w_win, w_sel_icmp;
   logic [15:0]        w_sel_length;
   logic [31:0]        w_sel_dest;
   logic [7:0]         w_ip_data;

   assign w_win = (r_state == IDLE) && (|req) && !ip_active;

   ip_tx_arb_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .i_req   (req),
      .i_start (w_start),
      .o_gnt   (w_pick_gnt),
      .o_idx   (w_pick_idx)
   );

`ifdef IP_TX_ARB_RR_EN
   logic [IDX_W-1:0] r_start;
   always_ff @(posedge clock) begin
      if (!reset)     r_start <= '0;
      else if (w_win) r_start <= IDX_W'(wrap_add(int'(w_pick_idx), 1, NUM_REQ));
   end
   assign w_start = r_start;
`else
   logic w_unused_idx;
   assign w_start      = '0;
   assign w_unused_idx = ^w_pick_idx;
`endif

   always_comb begin
      w_sel_icmp   = 1'b0;
      w_sel_length = '0;
      w_sel_dest   = '0;
      w_ip_data    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_pick_gnt[i]) begin
            w_sel_icmp   = req_is_icmp[i];
            w_sel_length = req_length[i*16 +: 16];
            w_sel_dest   = req_destination_ip[i*32 +: 32];
         end
         if ((r_state == SEND) && r_gnt[i]) w_ip_data = req_data[i*8 +: 8];
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_gnt       <= '0;
         r_rd        <= '0;
         r_done      <= '0;
         r_err       <= 1'b0;
         r_busy      <= 1'b0;
         r_tx_en     <= 1'b0;
         r_is_icmp   <= 1'b0;
         r_length    <= '0;
         r_dest      <= '0;
         r_cnt       <= '0;
         r_drain_cnt <= '0;
      end else begin
         // NOTE: sequential state uses <= so every register here sees pre-edge values.
         r_done <= '0;
         r_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_win) begin
                  r_gnt     <= w_pick_gnt;
                  r_is_icmp <= w_sel_icmp;
                  r_length  <= w_sel_length;
                  r_dest    <= w_sel_dest;
                  r_busy    <= 1'b1;
                  r_state   <= LOAD;
               end
            end
            LOAD: begin
               if (r_length == 16'd0) begin
                  r_done  <= r_gnt;
                  r_err   <= 1'b1;
                  r_gnt   <= '0;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_cnt   <= r_length;
                  r_tx_en <= 1'b1;
                  r_rd    <= r_gnt;
                  r_state <= SEND;
               end
            end
            SEND: begin
               // Leaving at count 1 keeps SEND at exactly length cycles without ever wrapping.
               if (r_cnt == 16'd1) begin
                  r_tx_en     <= 1'b0;
                  r_rd        <= '0;
                  r_drain_cnt <= '0;
                  r_state     <= DRAIN;
               end else begin
                  r_cnt <= r_cnt - 16'd1;
               end
            end
            DRAIN: begin
               if (!ip_active || (r_drain_cnt == DRAIN_LAST)) begin
                  r_done  <= r_gnt;
                  r_err   <= ip_active;
                  r_gnt   <= '0;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_drain_cnt <= r_drain_cnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign gnt               = r_gnt;
   assign rd                = r_rd;
   assign done              = r_done;
   assign err               = r_err;
   assign busy              = r_busy;
   assign ip_tx_enable      = r_tx_en;
   assign ip_is_icmp        = r_is_icmp;
   assign ip_length         = r_length;
   assign ip_destination_ip = r_dest;
   assign ip_data           = w_ip_data;

endmodule
